sd_cmd_responder: RTL
=====================

Name: sd_cmd_responder

Overview:
- Card-side endpoint of the SD CMD line.
- Receives 48-bit host command frames, where the host is the software bit-banged CMD/CLK pins, and checks CRC7.
- Presents each decoded command to local logic, then serialises a 48-bit response frame back onto CMD.
- Used in card-emulation and loopback builds to exercise the Nios SD driver without a physical card.

Parameters:
- NCR_CYCLES, 2, number of sd_clk falling edges from the command end bit to the response start bit; legal range 2..64.
- SYNC_STAGES, 2, synchroniser depth for sd_clk_in and cmd_in; legal range 2..3.

Ports:
- clk  input  1  system clock; must be at least 8x the sd_clk_in frequency.
- reset_n  input  1  asynchronous active-low reset.
- sd_clk_in  input  1  SD clock from the host; asynchronous to clk.
- cmd_in  input  1  CMD line sampled value.
- cmd_out  output  1  CMD drive value.
- cmd_oe  output  1  CMD output enable; the pad is tri-stated when 0.
- cmd_valid  output  1  decoded command available.
- cmd_index  output  6  command index.
- cmd_arg  output  32  command argument.
- cmd_crc_err  output  1  CRC7 mismatch or end bit equal to 0.
- cmd_ack  input  1  consumes the current command.
- rsp_skip  input  1  qualifies cmd_ack: the command gets no response.
- rsp_valid  input  1  response offered.
- rsp_ready  output  1  response accepted this cycle when high together with rsp_valid.
- rsp_index  input  6  response index field.
- rsp_arg  input  32  response payload.
- rsp_crc  input  7  response CRC7; used only when SD_RSP_AUTOCRC_EN is not defined.
- busy  output  1  a frame is being received, is pending, is waiting out NCR, or is transmitting.

Behaviour:
- Reset values: cmd_out=1, cmd_oe=0, cmd_valid=0, cmd_index=0, cmd_arg=0, cmd_crc_err=0, rsp_ready=0, busy=0, state=IDLE.
- Reset is asynchronous. Asserting it mid-frame releases CMD immediately and discards any partial frame.
- Edge detection: sd_clk_in and cmd_in pass through SYNC_STAGES flops. rise and fall are one-clk pulses on the synchronised clock.
- cmd_in is sampled only on rise. cmd_out changes only on fall.
- IDLE:
  - On rise with cmd_in=0 (start bit), clear the CRC and go to RX with bit count 1.
- RX:
  - Shift one bit per rise, MSB first.
  - Bit 1 (transmission bit) must be 1; a 0 means a card-origin frame, so abort to IDLE silently.
  - Bits 2..39 feed the CRC7 (polynomial x^7+x^3+1, initial value 0). The start and transmission bits also feed it.
  - Bits 40..46 are compared with the computed CRC. Bit 47 is the end bit.
  - After bit 47, latch index, arg and crc_err; assert cmd_valid; go to PEND.
- PEND:
  - rsp_ready=1 unless this is the same cycle as cmd_ack with rsp_skip=1.
  - cmd_ack=1 with rsp_skip=1: clear cmd_valid, go to IDLE.
  - cmd_ack=1 with rsp_skip=0: clear cmd_valid, stay in PEND.
  - rsp_valid and rsp_ready: load the 48-bit shift register {0,0,index,arg,crc,1}, clear cmd_valid (implicit ack), go to NCR.
  - Start bits seen on CMD while in PEND, NCR or TX are ignored.
- NCR:
  - Count fall events. On the NCR_CYCLES-th fall after entering NCR, set cmd_oe=1, drive the start bit, go to TX.
- TX:
  - Shift one bit per fall.
  - After the end bit has been driven for one full sd_clk period (next fall), set cmd_oe=0, cmd_out=1, go to IDLE.
- cmd_ack outside PEND is ignored. rsp_valid outside PEND is ignored and rsp_ready stays 0.
- busy=1 in RX, PEND, NCR and TX.

Optional Feature:
- SD_RSP_AUTOCRC_EN defined: the response CRC7 is computed over the first 40 transmitted bits while shifting, and rsp_crc is ignored.
- Undefined: rsp_crc is inserted verbatim. The CRC generator on the TX path is not built; the RX checker remains.

Decomposition:
- Shared package sd_pkg:
  - state enum {IDLE,RX,PEND,NCR,TX};
  - FRAME_BITS=48;
  - CRC7_POLY=7'h09;
  - start, transmission and end bit constants.
- Sub-module sd_crc7: serial CRC7 with clear, enable and bit inputs and 7-bit state. Instantiated once for RX and once for TX when SD_RSP_AUTOCRC_EN is defined.

Test Plan:
- CMD0 frame 0x40_00000000_95 -> cmd_valid=1, cmd_index=0, cmd_arg=0, cmd_crc_err=0.
- CMD8 frame 0x48_000001AA_87 -> cmd_index=8, cmd_arg=0x000001AA, cmd_crc_err=0.
- CMD8 with CRC byte 0x85 -> cmd_crc_err=1. Frame with transmission bit 0 -> cmd_valid stays 0, state returns to IDLE.
- After CMD0, respond with rsp_index=0, rsp_arg=0 under autocrc -> line carries 0x00_00000000_01. Start bit appears on the 2nd fall after the end bit. cmd_oe drops one period after the end bit.
- cmd_ack with rsp_skip=1, then an immediate second command -> second command decoded with no CMD drive in between.
- reset_n asserted at TX bit 20 -> cmd_oe=0 asynchronously; a following CMD0 decodes correctly.

Source files
------------

// File: rtl/sd_pkg.sv
// sd_pkg: shared types and frame constants for the SD CMD-line responder.
package sd_pkg;
    typedef enum logic [2:0] {IDLE, RX, PEND, NCR, TX} sd_state_t;
    localparam int FRAME_BITS = 48;
    localparam logic [6:0] CRC7_POLY = 7'h09;
    localparam logic START_BIT = 1'b0;
    localparam logic HOST_TX_BIT = 1'b1;
    localparam logic CARD_TX_BIT = 1'b0;
    localparam logic END_BIT = 1'b1;
endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 (x^7+x^3+1), MSB first, zero seed; clear with en folds the first bit into a fresh CRC.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);
    logic [6:0] base;
    assign base = clear ? 7'd0 : crc;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) crc <= '0;
        else if (en) crc <= {base[5:0], 1'b0} ^ ((bit_in ^ base[6]) ? CRC7_POLY : 7'd0);
        else if (clear) crc <= '0;
endmodule

// File: rtl/sd_cmd_responder.sv
// sd_cmd_responder: card-side SD CMD endpoint; decodes CRC7-checked host commands and serialises responses.
// Define SD_RSP_AUTOCRC_EN to generate the response CRC7 on the fly instead of sending rsp_crc.
module sd_cmd_responder
    import sd_pkg::*;
#(
    parameter int NCR_CYCLES  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sd_clk_in,
    input  logic        cmd_in,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        cmd_crc_err,
    input  logic        cmd_ack,
    input  logic        rsp_skip,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [5:0]  rsp_index,
    input  logic [31:0] rsp_arg,
    input  logic [6:0]  rsp_crc,
    output logic        busy
);
    sd_state_t state;
    logic [SYNC_STAGES-1:0] clk_sync, cmd_sync;
    logic clk_prev, rise, fall, cmd_s;
    logic [5:0] rx_cnt, tx_cnt, ncr_cnt;
    logic [44:0] rx_sr;
    logic [FRAME_BITS-1:0] tx_sr;
    logic [6:0] rx_crc;
    logic start_det, rx_crc_en, rsp_load, tx_fire, tx_bit;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            clk_sync <= '0;
            cmd_sync <= '1;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], sd_clk_in};
            cmd_sync <= {cmd_sync[SYNC_STAGES-2:0], cmd_in};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end

    assign rise = clk_sync[SYNC_STAGES-1] & ~clk_prev;
    assign fall = ~clk_sync[SYNC_STAGES-1] & clk_prev;
    assign cmd_s = cmd_sync[SYNC_STAGES-1];
    assign busy = state != IDLE;
    assign rsp_ready = state == PEND && !(cmd_ack && rsp_skip);
    assign rsp_load = rsp_ready && rsp_valid;
    assign start_det = rise && state == IDLE && cmd_s == START_BIT;
    assign rx_crc_en = start_det || (rise && state == RX && rx_cnt <= 6'd39);
    assign tx_fire = fall && ((state == NCR && ncr_cnt == 6'(NCR_CYCLES - 1)) ||
                              (state == TX && tx_cnt != 6'd48));

    sd_crc7 u_rx_crc (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (start_det),
        .en     (rx_crc_en),
        .bit_in (cmd_s),
        .crc    (rx_crc)
    );

`ifdef SD_RSP_AUTOCRC_EN
    logic [6:0] tx_crc;
    logic [5:0] tx_idx;
    assign tx_idx = state == TX ? tx_cnt : 6'd0;
    sd_crc7 u_tx_crc (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (rsp_load),
        .en     (tx_fire && tx_idx < 6'd40),
        .bit_in (tx_sr[FRAME_BITS-1]),
        .crc    (tx_crc)
    );
    // bits 40..46 come from the frozen generator, not from the loaded rsp_crc field
    assign tx_bit = (tx_idx >= 6'd40 && tx_idx <= 6'd46) ? tx_crc[3'(6'd46 - tx_idx)] : tx_sr[FRAME_BITS-1];
`else
    assign tx_bit = tx_sr[FRAME_BITS-1];
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            rx_cnt <= '0;
            tx_cnt <= '0;
            ncr_cnt <= '0;
            rx_sr <= '0;
            tx_sr <= '1;
            cmd_out <= 1'b1;
            cmd_oe <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_index <= '0;
            cmd_arg <= '0;
            cmd_crc_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_det) begin
                    state <= RX;
                    rx_cnt <= 6'd1;
                end
                RX: if (rise) begin
                    rx_sr <= {rx_sr[43:0], cmd_s};
                    rx_cnt <= rx_cnt + 6'd1;
                    // a 0 transmission bit marks a card-origin frame: drop it quietly
                    if (rx_cnt == 6'd1 && cmd_s != HOST_TX_BIT) state <= IDLE;
                    else if (rx_cnt == 6'd47) begin
                        cmd_index <= rx_sr[44:39];
                        cmd_arg <= rx_sr[38:7];
                        cmd_crc_err <= (rx_sr[6:0] != rx_crc) || (cmd_s != END_BIT);
                        cmd_valid <= 1'b1;
                        state <= PEND;
                    end
                end
                PEND: if (cmd_ack && rsp_skip) begin
                    cmd_valid <= 1'b0;
                    state <= IDLE;
                end else if (rsp_load) begin
                    tx_sr <= {START_BIT, CARD_TX_BIT, rsp_index, rsp_arg, rsp_crc, END_BIT};
                    cmd_valid <= 1'b0;
                    ncr_cnt <= '0;
                    state <= NCR;
                end else if (cmd_ack) cmd_valid <= 1'b0;
                NCR: if (fall) begin
                    if (tx_fire) begin
                        cmd_oe <= 1'b1;
                        cmd_out <= tx_bit;
                        tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b1};
                        tx_cnt <= 6'd1;
                        state <= TX;
                    end else ncr_cnt <= ncr_cnt + 6'd1;
                end
                TX: if (fall) begin
                    if (tx_fire) begin
                        cmd_out <= tx_bit;
                        tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b1};
                        tx_cnt <= tx_cnt + 6'd1;
                    end else begin
                        cmd_oe <= 1'b0;
                        cmd_out <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule
